// File: rtl/genius_vga_pkg.sv
// Shared types and constants for the VGA frame monitor: FSM states,
// default frame geometry and counter widths.
package genius_vga_pkg;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACTIVE  = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FRAME_CNT_W  = 19;
  localparam int LINE_CNT_W   = 10;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers an active-low sync input and flags its falling edge, comparing
// the registered value against the previous registered value.
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;

  // Idle level of an active-low sync is high, so reset there to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= sync_in;
      sync_p1 <= sync_p0;
    end
  end

  assign fall = sync_p1 & ~sync_p0;

endmodule

// File: rtl/vga_frame_monitor.sv
// Recovers pixel coordinates from a VGA stream and reports per-frame pixel,
// colour-key and line counts together with geometry error flags.
module vga_frame_monitor
  import genius_vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic                   CLOCK_25,
  input  logic                   RESET,
  input  logic                   VGA_HS,
  input  logic                   VGA_VS,
  input  logic                   VGA_BLANK_N,
  input  logic [7:0]             VGA_R,
  input  logic [7:0]             VGA_G,
  input  logic [7:0]             VGA_B,
  input  logic [7:0]             KEY_R,
  input  logic [7:0]             KEY_G,
  input  logic [7:0]             KEY_B,
  output logic [LINE_CNT_W-1:0]  X,
  output logic [LINE_CNT_W-1:0]  Y,
  output logic [FRAME_CNT_W-1:0] PIX_COUNT,
  output logic [FRAME_CNT_W-1:0] KEY_COUNT,
  output logic [LINE_CNT_W-1:0]  LINE_COUNT,
  output logic                   FRAME_VALID,
  output logic                   LINE_ERR,
  output logic                   FRAME_ERR,
  output logic                   LOCKED
);

  localparam logic [LINE_CNT_W-1:0]  LINE_PIX  = LINE_CNT_W'(H_ACTIVE);
  localparam logic [LINE_CNT_W-1:0]  FRAME_LNS = LINE_CNT_W'(V_ACTIVE);
  localparam logic [FRAME_CNT_W-1:0] FRAME_PIX = FRAME_CNT_W'(H_ACTIVE * V_ACTIVE);

  function automatic logic [FRAME_CNT_W-1:0] sat_inc_frame(input logic [FRAME_CNT_W-1:0] v);
    return (&v) ? v : v + FRAME_CNT_W'(1);
  endfunction

  function automatic logic [LINE_CNT_W-1:0] sat_inc_line(input logic [LINE_CNT_W-1:0] v);
    return (&v) ? v : v + LINE_CNT_W'(1);
  endfunction

  state_t                 state;
  logic                   blank_p0;
  logic [23:0]            rgb_p0;
  logic                   hs_fall;
  logic                   vs_fall;
  logic [23:0]            key_q;
  logic [FRAME_CNT_W-1:0] pix_acc, key_acc;
  logic [LINE_CNT_W-1:0]  line_acc, line_pix;
  logic                   line_err_acc;
  logic                   start_frame;

  logic [FRAME_CNT_W-1:0] pix_n, key_n;
  logic [LINE_CNT_W-1:0]  lines_n, lpix_n, x_n, y_n;
  logic                   err_n;

  // Stage p0: single input register; all detection works on this copy.
  vga_sync_edge u_hs_edge (.clk(CLOCK_25), .rst(RESET), .sync_in(VGA_HS), .fall(hs_fall));
  vga_sync_edge u_vs_edge (.clk(CLOCK_25), .rst(RESET), .sync_in(VGA_VS), .fall(vs_fall));

  always_ff @(posedge CLOCK_25) begin
    if (RESET) blank_p0 <= 1'b0;
    else       blank_p0 <= VGA_BLANK_N;
  end

  always_ff @(posedge CLOCK_25) begin
    rgb_p0 <= {VGA_R, VGA_G, VGA_B};
  end

  // Pixel counted first, then a sync edge closes the line, so an HS edge
  // coinciding with VS still lands its line in the closing frame.
  always_comb begin
    pix_n   = pix_acc;
    key_n   = key_acc;
    lines_n = line_acc;
    lpix_n  = line_pix;
    x_n     = X;
    y_n     = Y;
    err_n   = line_err_acc;
    if (blank_p0) begin
      pix_n  = sat_inc_frame(pix_acc);
      lpix_n = sat_inc_line(line_pix);
      x_n    = sat_inc_line(X);
      if (rgb_p0 == key_q) key_n = sat_inc_frame(key_acc);
    end
    if (hs_fall) x_n = '0;
    if ((hs_fall || vs_fall) && (lpix_n != '0)) begin
      y_n     = sat_inc_line(Y);
      lines_n = sat_inc_line(line_acc);
      if (lpix_n != LINE_PIX) err_n = 1'b1;
      lpix_n  = '0;
    end
  end

  assign start_frame = ((state == WAIT_VS) && vs_fall) || (state == REPORT);

  // Stage p1: frame FSM, accumulators and report registers.
  always_ff @(posedge CLOCK_25) begin
    if (RESET) begin
      state        <= WAIT_VS;
      pix_acc      <= '0;
      key_acc      <= '0;
      line_acc     <= '0;
      line_pix     <= '0;
      line_err_acc <= 1'b0;
      key_q        <= '0;
      X            <= '0;
      Y            <= '0;
      PIX_COUNT    <= '0;
      KEY_COUNT    <= '0;
      LINE_COUNT   <= '0;
      FRAME_VALID  <= 1'b0;
      LINE_ERR     <= 1'b0;
      FRAME_ERR    <= 1'b0;
      LOCKED       <= 1'b0;
    end else begin
      FRAME_VALID <= 1'b0;
      case (state)
        WAIT_VS: begin
          if (vs_fall) begin
            state  <= ACTIVE;
            LOCKED <= 1'b1;
          end
        end
        ACTIVE: begin
          pix_acc      <= pix_n;
          key_acc      <= key_n;
          line_acc     <= lines_n;
          line_pix     <= lpix_n;
          line_err_acc <= err_n;
          X            <= x_n;
          Y            <= y_n;
          if (vs_fall) begin
            state       <= REPORT;
            PIX_COUNT   <= pix_n;
            KEY_COUNT   <= key_n;
            LINE_COUNT  <= lines_n;
            LINE_ERR    <= err_n;
            FRAME_ERR   <= (lines_n != FRAME_LNS) || err_n || (pix_n != FRAME_PIX);
            FRAME_VALID <= 1'b1;
          end
        end
        REPORT:  state <= ACTIVE;
        default: state <= WAIT_VS;
      endcase
      // Overrides the ACTIVE updates above; the key is latched only here so
      // mid-frame key changes wait for the next frame.
      if (start_frame) begin
        pix_acc      <= '0;
        key_acc      <= '0;
        line_acc     <= '0;
        line_pix     <= '0;
        line_err_acc <= 1'b0;
        Y            <= '0;
        key_q        <= {KEY_R, KEY_G, KEY_B};
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed scoreboard bench for vga_frame_monitor on a reduced 16x12 frame.
module tb_vga_frame_monitor;

  localparam int H = 16;
  localparam int V = 12;

  localparam logic [23:0] K1  = 24'h123456;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] CA  = 24'h0000AA;
  localparam logic [23:0] CB  = 24'h00BB00;

  logic        clk = 1'b0;
  logic        rst, hs, vs, blank_n;
  logic [7:0]  vr, vg, vb, kr, kg, kb;
  logic [9:0]  x, y, line_count;
  logic [18:0] pix_count, key_count;
  logic        frame_valid, line_err, frame_err, locked;

  typedef struct packed {
    logic [18:0] pix;
    logic [18:0] key;
    logic [9:0]  lines;
    logic        lerr;
    logic        ferr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vga_frame_monitor #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .CLOCK_25(clk), .RESET(rst), .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n),
    .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .KEY_R(kr), .KEY_G(kg), .KEY_B(kb),
    .X(x), .Y(y), .PIX_COUNT(pix_count), .KEY_COUNT(key_count), .LINE_COUNT(line_count),
    .FRAME_VALID(frame_valid), .LINE_ERR(line_err), .FRAME_ERR(frame_err), .LOCKED(locked)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic push_exp(input int pix, input int key, input int lines, input bit lerr, input bit ferr);
    exp_t e;
    e.pix   = 19'(pix);
    e.key   = 19'(key);
    e.lines = 10'(lines);
    e.lerr  = lerr;
    e.ferr  = ferr;
    exp_q.push_back(e);
  endtask

  task automatic set_key(input logic [23:0] k);
    {kr, kg, kb} = k;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      blank_n = 1'b0;
      {vr, vg, vb} = 24'h0;
      @(negedge clk);
    end
  endtask

  task automatic vsync();
    vs = 1'b0;
    idle(3);
    vs = 1'b1;
    idle(4);
  endtask

  function automatic logic [23:0] color(input int mode, input int px, input int py);
    case (mode)
      0:       return K1;
      1:       return (px >= 4 && px < 8 && py >= 3 && py < 7) ? RED : 24'h0;
      default: return (py < 4) ? CA : CB;
    endcase
  endfunction

  // Drives the active lines of one frame; negative line indices disable an option.
  task automatic lines(input int n, input int mode, input int short_line,
                       input int key_line, input int reset_line, input int ycheck_line);
    for (int l = 0; l < n; l++) begin
      if (l == ycheck_line) begin
        chk("y_at_line_start", y, l);
        chk("x_at_line_start", x, 0);
      end
      if (l == key_line) set_key(CB);
      if (l == reset_line) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      for (int p = 0; p < ((l == short_line) ? H - 1 : H); p++) begin
        blank_n = 1'b1;
        {vr, vg, vb} = color(mode, p, l);
        @(negedge clk);
      end
      idle(2);
      hs = 1'b0;
      idle(2);
      hs = 1'b1;
      idle(2);
    end
  endtask

  // Monitor: every FRAME_VALID pulse is matched against the oldest expected report.
  initial begin
    bit   width_pending = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (width_pending) begin
        chk("frame_valid_width", frame_valid, 0);
        width_pending = 1'b0;
      end
      if (frame_valid === 1'b1) begin
        width_pending = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_valid actual=1 expected=0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("pix_count", pix_count, e.pix);
          chk("key_count", key_count, e.key);
          chk("line_count", line_count, e.lines);
          chk("line_err", line_err, e.lerr);
          chk("frame_err", frame_err, e.ferr);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; hs = 1'b1; vs = 1'b1; blank_n = 1'b0;
    {vr, vg, vb} = 24'h0;
    set_key(24'h0);
    repeat (3) @(negedge clk);
    chk("rst_pix_count", pix_count, 0);
    chk("rst_key_count", key_count, 0);
    chk("rst_line_count", line_count, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_line_err", line_err, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_locked", locked, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    rst = 1'b0;
    idle(5);
    chk("unlocked_before_vs", locked, 0);

    set_key(K1);
    vsync();
    chk("locked_after_vs", locked, 1);

    // Full frame, all pixels equal to the key.
    lines(V, 0, -1, -1, -1, 7);
    set_key(RED);
    push_exp(H * V, H * V, V, 0, 0);
    vsync();

    // 4x4 red sprite on black.
    lines(V, 1, -1, -1, -1, -1);
    set_key(K1);
    push_exp(H * V, 16, V, 0, 0);
    vsync();

    // One short line.
    lines(V, 0, 5, -1, -1, -1);
    push_exp(H * V - 1, H * V - 1, V, 1, 1);
    vsync();

    // One extra line.
    lines(V + 1, 0, -1, -1, -1, -1);
    set_key(CA);
    push_exp(H * (V + 1), H * (V + 1), V + 1, 0, 1);
    vsync();

    // Key changed mid-frame: old key still applies to this report.
    lines(V, 2, -1, 2, -1, -1);
    push_exp(H * V, 4 * H, V, 0, 0);
    vsync();

    // Next frame counts the new key.
    lines(V, 2, -1, -1, -1, -1);
    push_exp(H * V, 8 * H, V, 0, 0);
    vsync();

    idle(20);
    chk("hold_pix_count", pix_count, H * V);
    chk("hold_key_count", key_count, 8 * H);

    // Reset mid-frame: report cleared and no pulse until two VS falls later.
    lines(V, 0, -1, -1, 5, -1);
    chk("midrst_pix_count", pix_count, 0);
    chk("midrst_key_count", key_count, 0);
    chk("midrst_line_count", line_count, 0);
    chk("midrst_line_err", line_err, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_locked", locked, 0);
    set_key(K1);
    vsync();
    chk("relocked", locked, 1);
    lines(V, 0, -1, -1, -1, -1);
    push_exp(H * V, H * V, V, 0, 0);
    vsync();

    idle(10);
    chk("all_reports_seen", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_frame_monitor.md
VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 CLOCK_25  in  1  pixel clock; the only clock; all logic on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 VGA_HS  in  1  horizontal sync, active low.
REQ-006 VGA_VS  in  1  vertical sync, active low.
REQ-007 VGA_BLANK_N  in  1  high = active pixel.
REQ-008 VGA_R, VGA_G, VGA_B  in  8 each  pixel colour.
REQ-009 KEY_R, KEY_G, KEY_B  in  8 each  colour key to count.
REQ-010 X, Y  out  10 each  recovered coordinate of the current registered pixel.
REQ-011 PIX_COUNT  out  19  active pixels in the last complete frame.
REQ-012 KEY_COUNT  out  19  active pixels equal to the key in the last complete frame.
REQ-013 LINE_COUNT  out  10  lines containing at least one active pixel in the last frame.
REQ-014 FRAME_VALID  out  1  one-cycle pulse when the report outputs update.
REQ-015 LINE_ERR, FRAME_ERR  out  1 each  geometry error flags for the last frame.
REQ-016 LOCKED  out  1  high once a frame start has been seen.

Function
REQ-017 The block SHALL register all VGA inputs once; all detection uses the registered copy, so latency from input to X/Y is 1 cycle.
REQ-018 Edges SHALL be falling edges of the registered HS/VS versus their previous registered value.
REQ-019 FSM states SHALL be WAIT_VS, ACTIVE and REPORT. WAIT_VS goes to ACTIVE on a VS falling edge. ACTIVE goes to REPORT on the next VS falling edge. REPORT goes to ACTIVE after 1 cycle.
REQ-020 On entry to ACTIVE, the frame accumulators and Y SHALL clear to 0, and KEY_R/G/B SHALL be latched; a key change mid-frame takes effect at the next frame.
REQ-021 In ACTIVE, each cycle with BLANK_N=1 SHALL increment X, the line pixel count and the frame pixel count; the frame key count also increments if RGB equals the latched key on all 24 bits.
REQ-022 On an HS falling edge, X SHALL clear to 0. If the line pixel count is nonzero:
  - Y and the line counter increment;
  - LINE_ERR_acc sets if the line pixel count is not equal to H_ACTIVE;
  - the line pixel count clears.
REQ-023 Frame counters SHALL saturate at 2^19-1. The line counter and Y SHALL saturate at 1023. X SHALL saturate at 1023.
REQ-024 In REPORT:
  - a line still open (nonzero line pixel count) is closed as in REQ-022;
  - PIX_COUNT, KEY_COUNT and LINE_COUNT load the accumulators;
  - LINE_ERR loads LINE_ERR_acc;
  - FRAME_ERR loads (lines not equal to V_ACTIVE) OR LINE_ERR_acc OR (pixels not equal to H_ACTIVE*V_ACTIVE);
  - FRAME_VALID pulses for exactly 1 cycle.
REQ-025 The REPORT cycle SHALL also perform the REQ-020 clear and latch, so no frame is skipped.
REQ-026 Report outputs SHALL hold their values between reports.
REQ-027 An HS edge in the same cycle as a VS edge SHALL be treated as HS first (line closed), then VS.
REQ-028 In WAIT_VS, the accumulators SHALL stay 0, FRAME_VALID SHALL stay 0, and LOCKED SHALL stay 0. LOCKED sets on leaving WAIT_VS.

Reset
REQ-029 RESET SHALL force WAIT_VS and set every output, accumulator and latched key to 0. This applies mid-frame too; no FRAME_VALID is issued for the interrupted frame.
REQ-030 RESET SHALL take priority over all other events in the same cycle.

Structure
REQ-031 The shared package genius_vga_pkg SHALL hold the following:
  - the FSM state enum;
  - the H_ACTIVE/V_ACTIVE defaults;
  - the count width constants (19, 10).
REQ-032 The edge detection SHALL be one sub-module, vga_sync_edge (register plus falling-edge pulse), instantiated for HS and VS.

Verification
REQ-033 Full frame: 640x480 frame, every pixel equal to the key → 1 cycle after the second VS fall, FRAME_VALID=1 for 1 cycle, PIX_COUNT=307200, KEY_COUNT=307200, LINE_COUNT=480, LINE_ERR=0, FRAME_ERR=0.
REQ-034 Sprite: 40x40 square of key colour 0xFF/0x00/0x00 on black → KEY_COUNT=1600, PIX_COUNT=307200.
REQ-035 Short line: line 100 has 639 active pixels → LINE_ERR=1, FRAME_ERR=1, PIX_COUNT=307199.
REQ-036 Extra line: frame of 481 active lines → LINE_COUNT=481, FRAME_ERR=1, LINE_ERR=0.
REQ-037 Reset mid-frame: RESET pulse at line 200 → all outputs 0, LOCKED=0, and no FRAME_VALID until 2 VS falls later.
REQ-038 Key change: key changed mid-frame → the current report uses the old key; the next frame counts the new key.
